// File: rtl/multi_level_to_pulse.sv
// multi_level_to_pulse: per-channel sync, debounce and edge-to-pulse; define LTP_REPEAT_EN for auto-repeat
// while a channel is held high in a rise-pulsing mode.
module multi_level_to_pulse #(
    parameter int N_CH          = 4,
    parameter int DEBOUNCE_CYC  = 4,
    parameter int REPEAT_DELAY  = 32,
    parameter int REPEAT_PERIOD = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N_CH-1:0] level_in,
    input  logic [1:0]      mode,
    output logic [N_CH-1:0] level_q,
    output logic [N_CH-1:0] pulse,
    output logic            any_pulse
);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
`ifdef LTP_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
`endif
    typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} state_t;
    logic [N_CH-1:0] s1_q, s2_q;
    logic            rise_m, fall_m;
    assign rise_m    = ~mode[0];
    assign fall_m    = mode[0] ^ mode[1];
    assign any_pulse = |pulse;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= level_in;
            s2_q <= s1_q;
        end
    end
    genvar g;
    for (g = 0; g < N_CH; g++) begin : g_ch
        logic [DW-1:0] cnt_q, cnt_d;
        logic          lvl_q, lvl_d, pulse_q, pulse_d, rep;
        state_t        st_q, st_d;
        assign level_q[g] = lvl_q;
        assign pulse[g]   = pulse_q;
        always_comb begin
            cnt_d = '0;
            lvl_d = lvl_q;
            if (s2_q[g] != lvl_q) begin
                if (cnt_q == DW'(DEBOUNCE_CYC - 1)) lvl_d = ~lvl_q;
                else cnt_d = cnt_q + 1'b1;
            end
            case (st_q)
                S_LOW:   st_d = lvl_q ? S_RISE : S_LOW;
                S_RISE:  st_d = S_HIGH;
                S_HIGH:  st_d = lvl_q ? S_HIGH : S_FALL;
                default: st_d = S_LOW;
            endcase
            pulse_d = (st_d == S_RISE && rise_m) || (st_d == S_FALL && fall_m) || rep;
        end
`ifdef LTP_REPEAT_EN
        // Down-counter: loaded on the cycle after the rise pulse, fires at 1, then reloads the period.
        logic [RW-1:0] rcnt_q, rcnt_d;
        always_comb begin
            rcnt_d = '0;
            rep    = 1'b0;
            if (rise_m && st_q == S_RISE) begin
                rcnt_d = RW'(REPEAT_DELAY - 1);
            end else if (rise_m && st_q == S_HIGH && lvl_q && rcnt_q != '0) begin
                rep    = (rcnt_q == RW'(1));
                rcnt_d = rep ? RW'(REPEAT_PERIOD) : rcnt_q - 1'b1;
            end
        end
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) rcnt_q <= '0;
            else rcnt_q <= rcnt_d;
        end
`else
        assign rep = 1'b0;
`endif
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q   <= '0;
                lvl_q   <= 1'b0;
                st_q    <= S_LOW;
                pulse_q <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                lvl_q   <= lvl_d;
                st_q    <= st_d;
                pulse_q <= pulse_d;
            end
        end
    end
endmodule

// File: tb/tb_multi_level_to_pulse.sv
// tb_multi_level_to_pulse: directed and random stimulus against a history-based model of the
// debounce window and edge/mode pulse rules.
module tb_multi_level_to_pulse;
    localparam int N = 4, D = 4, RD = 32, RP = 8;
    logic clk = 1'b0, reset_n, any_pulse;
    logic [N-1:0] level_in, level_q, pulse;
    logic [1:0] mode;
    int checks = 0, passed = 0;
    int n, last_flip[N], rise_t[N];
    bit rep_ok[N];
    logic [N-1:0] smp[int], lh[int];
    logic [N-1:0] exp_lvl, exp_pulse;

    multi_level_to_pulse #(.N_CH(N), .DEBOUNCE_CYC(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .clk(clk), .reset_n(reset_n), .level_in(level_in), .mode(mode),
        .level_q(level_q), .pulse(pulse), .any_pulse(any_pulse));

    always #5 clk = ~clk;

    function automatic logic [N-1:0] hist_s(int k);
        return (k >= 1 && smp.exists(k)) ? smp[k] : '0;
    endfunction
    function automatic logic [N-1:0] hist_l(int k);
        return (k >= 1 && lh.exists(k)) ? lh[k] : '0;
    endfunction

    task automatic reset_model();
        n = 0;
        smp.delete();
        lh.delete();
        exp_lvl = '0;
        exp_pulse = '0;
        for (int c = 0; c < N; c++) begin
            last_flip[c] = 0;
            rise_t[c] = 0;
            rep_ok[c] = 0;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        reset_model();
    endtask

    // Level flips once the synced input has disagreed for D whole cycles since the last flip;
    // a pulse follows one cycle after each flip if the mode admits that edge direction.
    task automatic tick();
        logic [N-1:0] in_at, p1, p2, s, np, nl;
        logic [1:0] m_at;
        bit ok;
        in_at = level_in;
        m_at = mode;
        @(posedge clk);
        #1;
        n++;
        smp[n] = in_at;
        p1 = hist_l(n - 1);
        p2 = hist_l(n - 2);
        np = '0;
        nl = exp_lvl;
        for (int c = 0; c < N; c++) begin
            if (p1[c] != p2[c]) np[c] = p1[c] ? ~m_at[0] : m_at[0] ^ m_at[1];
`ifdef LTP_REPEAT_EN
            if (p1[c] && !p2[c]) begin
                rise_t[c] = n;
                rep_ok[c] = 1;
            end else if (!p1[c] || m_at[0]) rep_ok[c] = 0;
            if (rep_ok[c] && n - rise_t[c] >= RD && (n - rise_t[c] - RD) % RP == 0) np[c] = 1'b1;
`endif
            ok = (n - D >= last_flip[c]);
            for (int k = n - D - 1; k <= n - 2; k++) begin
                s = hist_s(k);
                if (s[c] == exp_lvl[c]) ok = 0;
            end
            if (ok) begin
                nl[c] = ~exp_lvl[c];
                last_flip[c] = n;
            end
        end
        lh[n] = nl;
        exp_lvl = nl;
        exp_pulse = np;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        level_in = '0;
        mode = 2'b00;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (level_q !== '0) $display("FAIL reset_level_q got %h want 0", level_q);
        else passed++;
        checks++;
        if (pulse !== '0 || any_pulse !== 1'b0) $display("FAIL reset_pulse got %h/%b want 0/0", pulse, any_pulse);
        else passed++;
        reset_n = 1'b1;
        reset_model();
    endtask

    task automatic test_single_rise();
        int rise_n = -1, pulse_n = -1, pcount = 0;
        do_reset();
        mode = 2'b00;
        level_in = '0;
        for (int i = 0; i < 40; i++) begin
            if (n == 9) level_in[0] = 1'b1;
            if (n == 30) level_in[0] = 1'b0;
            tick();
            checks++;
            if (pulse !== exp_pulse || level_q !== exp_lvl || any_pulse !== |exp_pulse)
                $display("FAIL single_rise n=%0d pulse %h want %h level_q %h want %h any %b", n, pulse, exp_pulse, level_q, exp_lvl, any_pulse);
            else passed++;
            if (level_q[0] && rise_n < 0) rise_n = n;
            if (pulse[0]) begin
                pcount++;
                if (pulse_n < 0) pulse_n = n;
            end
        end
        checks++;
        if (rise_n !== 15) $display("FAIL rise_latency got edge %0d want 15", rise_n);
        else passed++;
        checks++;
        if (pulse_n !== 16 || pcount !== 1) $display("FAIL pulse_latency got edge %0d count %0d want 16 count 1", pulse_n, pcount);
        else passed++;
    endtask

    task automatic test_glitch();
        int seen = 0;
        do_reset();
        mode = 2'b00;
        level_in = '0;
        for (int i = 0; i < 20; i++) begin
            level_in[1] = (i >= 3 && i < 6);
            tick();
            checks++;
            if (pulse !== exp_pulse || level_q !== exp_lvl || any_pulse !== |exp_pulse)
                $display("FAIL glitch n=%0d pulse %h want %h level_q %h want %h", n, pulse, exp_pulse, level_q, exp_lvl);
            else passed++;
            if (level_q[1] || pulse[1]) seen++;
        end
        checks++;
        if (seen !== 0) $display("FAIL glitch_ignored got %0d active cycles want 0", seen);
        else passed++;
    endtask

    task automatic test_modes();
        int modes[3] = '{2, 1, 3};
        int want[3] = '{2, 1, 0};
        for (int m = 0; m < 3; m++) begin
            int cnt = 0, first = -1, last = -1, hi = 0;
            do_reset();
            mode = 2'(modes[m]);
            level_in = '0;
            for (int i = 0; i < 50; i++) begin
                level_in[2] = (i >= 2 && i < 22);
                tick();
                checks++;
                if (pulse !== exp_pulse || level_q !== exp_lvl || any_pulse !== |exp_pulse)
                    $display("FAIL modes m=%0d n=%0d pulse %h want %h level_q %h want %h", modes[m], n, pulse, exp_pulse, level_q, exp_lvl);
                else passed++;
                if (level_q[2]) hi++;
                if (pulse[2]) begin
                    cnt++;
                    if (first < 0) first = n;
                    last = n;
                end
            end
            checks++;
            if (cnt !== want[m] || hi !== 20) $display("FAIL mode_count m=%0d got %0d pulses %0d high want %0d pulses 20 high", modes[m], cnt, hi, want[m]);
            else passed++;
            if (modes[m] == 2) begin
                checks++;
                if (last - first !== 20) $display("FAIL both_spacing got %0d want 20", last - first);
                else passed++;
            end
        end
    endtask

    task automatic test_simultaneous();
        int full = 0, other = 0;
        do_reset();
        mode = 2'b00;
        level_in = '0;
        for (int i = 0; i < 16; i++) begin
            if (i == 1) level_in = '1;
            tick();
            checks++;
            if (pulse !== exp_pulse || level_q !== exp_lvl || any_pulse !== |exp_pulse)
                $display("FAIL simultaneous n=%0d pulse %h want %h level_q %h want %h", n, pulse, exp_pulse, level_q, exp_lvl);
            else passed++;
            if (pulse == 4'hF) full++;
            else if (pulse != 4'h0) other++;
        end
        checks++;
        if (full !== 1 || other !== 0) $display("FAIL simultaneous_count got %0d full %0d partial want 1 0", full, other);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int pn = -1;
        do_reset();
        mode = 2'b00;
        level_in = 4'b0001;
        for (int i = 0; i < 20 && pn < 0; i++) begin
            tick();
            if (pulse[0]) pn = n;
        end
        checks++;
        if (pn !== D + 3) $display("FAIL pre_reset_pulse got edge %0d want %0d", pn, D + 3);
        else passed++;
        reset_n = 1'b0;
        #1;
        checks++;
        if (pulse !== '0 || level_q !== '0 || any_pulse !== 1'b0)
            $display("FAIL async_reset got pulse %h level_q %h any %b want 0", pulse, level_q, any_pulse);
        else passed++;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        reset_model();
        pn = -1;
        for (int i = 0; i < 15; i++) begin
            tick();
            checks++;
            if (pulse !== exp_pulse || level_q !== exp_lvl || any_pulse !== |exp_pulse)
                $display("FAIL reset_mid n=%0d pulse %h want %h level_q %h want %h", n, pulse, exp_pulse, level_q, exp_lvl);
            else passed++;
            if (pulse[0] && pn < 0) pn = n;
        end
        checks++;
        if (pn !== D + 3) $display("FAIL post_reset_pulse got edge %0d want %0d", pn, D + 3);
        else passed++;
    endtask

    task automatic test_repeat();
        int cnt = 0, want;
`ifdef LTP_REPEAT_EN
        want = 5;
`else
        want = 1;
`endif
        do_reset();
        mode = 2'b00;
        level_in = '0;
        for (int i = 0; i < 100; i++) begin
            level_in[3] = (i >= 1 && i < 61);
            tick();
            checks++;
            if (pulse !== exp_pulse || level_q !== exp_lvl || any_pulse !== |exp_pulse)
                $display("FAIL repeat n=%0d pulse %h want %h level_q %h want %h", n, pulse, exp_pulse, level_q, exp_lvl);
            else passed++;
            if (pulse[3]) cnt++;
        end
        checks++;
        if (cnt !== want) $display("FAIL repeat_count got %0d want %0d", cnt, want);
        else passed++;
    endtask

    task automatic test_random();
        do_reset();
        mode = 2'b00;
        level_in = '0;
        for (int i = 0; i < 1600; i++) begin
            if (i < 1000) begin
                if ($urandom_range(0, 3) == 0) level_in[$urandom_range(0, N - 1)] ^= 1'b1;
            end else if ($urandom_range(0, 1) == 0) level_in[$urandom_range(0, N - 1)] ^= 1'b1;
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            tick();
            checks++;
            if (pulse !== exp_pulse || level_q !== exp_lvl || any_pulse !== |exp_pulse)
                $display("FAIL random n=%0d mode %b pulse %h want %h level_q %h want %h", n, mode, pulse, exp_pulse, level_q, exp_lvl);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_single_rise();
        test_glitch();
        test_modes();
        test_simultaneous();
        test_reset_mid();
        test_repeat();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
